// File: rtl/cut_bist_driver.sv
// LFSR pattern generator + MISR response compactor driving a combinational CUT.
// Optional `CUT_PIPE_EN registers resp_in and adds a one-cycle DRAIN state.
module cut_bist_driver #(
    parameter int                    IN_W      = 14,
    parameter int                    OUT_W     = 8,
    parameter int                    N_PAT     = 256,
    parameter logic [IN_W-1:0]       LFSR_TAPS = 14'h2015,
    parameter logic [IN_W-1:0]       LFSR_SEED = 14'h0001,
    parameter logic [OUT_W-1:0]      MISR_POLY = 8'h1D,
    parameter logic [OUT_W-1:0]      MISR_SEED = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] golden_sig,
    input  logic [OUT_W-1:0] resp_in,
    output logic [IN_W-1:0]  pat_out,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] sig,
    output logic             pass
);

    localparam int CNT_W = $clog2(N_PAT + 1);
    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [IN_W-1:0]  SEED_EFF = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    pat_q, pat_d;
    logic [OUT_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0]    lfsr_nxt;
    logic [OUT_W-1:0]   misr_shift;
    logic [OUT_W-1:0]   misr_resp;

    always_comb begin
        lfsr_nxt = (pat_q >> 1) ^ (pat_q[0] ? LFSR_TAPS : '0);
    end

    always_comb begin
        misr_shift = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? MISR_POLY : '0);
    end

`ifdef CUT_PIPE_EN
    logic [OUT_W-1:0] resp_q, resp_d;
    logic             absorb_q, absorb_d;

    always_comb begin
        resp_d   = resp_in;
        absorb_d = (state_q == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q   <= '0;
            absorb_q <= 1'b0;
        end else begin
            resp_q   <= resp_d;
            absorb_q <= absorb_d;
        end
    end

    assign misr_resp = resp_q;
`else
    assign misr_resp = resp_in;
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
`ifdef CUT_PIPE_EN
        // Registered responses lag the pattern by one cycle.
        if (absorb_q) begin
            sig_d = misr_shift ^ misr_resp;
        end
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pat_d   = SEED_EFF;
                    sig_d   = MISR_SEED;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
`ifndef CUT_PIPE_EN
                sig_d = misr_shift ^ misr_resp;
`endif
                pat_d = lfsr_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
`ifdef CUT_PIPE_EN
                    state_d = ST_DRAIN;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= SEED_EFF;
            sig_q   <= MISR_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pat_out = pat_q;
    assign sig     = sig_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);
    assign pass    = done && (sig_q == golden_sig);

endmodule

// File: tb/tb_cut_bist_driver.sv
// Directed bench for cut_bist_driver: four instances with different pattern counts,
// a vector table for short runs, and hand-written reset/protocol/full-period sequences.
module tb_cut_bist_driver;

`ifdef CUT_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] start_v = '0;
    always #5 clk = ~clk;

    logic [7:0]  resp_a = '0, resp_b = '0, gold_a = '0, gold_b = '0, gold_c = '0, gold_d = '0;
    logic [7:0]  resp_c, resp_d;
    logic [13:0] pat_a, pat_b, pat_c, pat_d;
    logic [7:0]  sig_a, sig_b, sig_c, sig_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;
    logic        pass_a, pass_b, pass_c, pass_d;

    int checks = 0;
    int failures = 0;

    function automatic logic [13:0] t_lfsr(input logic [13:0] p);
        logic [13:0] r;
        r = {1'b0, p[13:1]};
        if (p[0]) r = r ^ 14'h2015;
        return r;
    endfunction

    function automatic logic [7:0] t_misr(input logic [7:0] s, input logic [7:0] r);
        logic [7:0] n;
        n = {s[6:0], 1'b0};
        if (s[7]) n = n ^ 8'h1D;
        return n ^ r;
    endfunction

    // Stand-in combinational CUT netlist.
    function automatic logic [7:0] cut_f(input logic [13:0] p);
        return p[7:0] ^ {p[13:8], p[1:0]} ^ {p[2:0], p[13:9]};
    endfunction

    function automatic logic [7:0] model_sig(input int n);
        logic [13:0] p;
        logic [7:0]  s;
        p = 14'h0001;
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            s = t_misr(s, cut_f(p));
            p = t_lfsr(p);
        end
        return s;
    endfunction

    assign resp_c = cut_f(pat_c);
    assign resp_d = cut_f(pat_d);

    cut_bist_driver #(.N_PAT(2)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .golden_sig(gold_a), .resp_in(resp_a),
        .pat_out(pat_a), .busy(busy_a), .done(done_a), .sig(sig_a), .pass(pass_a));
    cut_bist_driver #(.N_PAT(1)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .golden_sig(gold_b), .resp_in(resp_b),
        .pat_out(pat_b), .busy(busy_b), .done(done_b), .sig(sig_b), .pass(pass_b));
    cut_bist_driver #(.N_PAT(16)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .golden_sig(gold_c), .resp_in(resp_c),
        .pat_out(pat_c), .busy(busy_c), .done(done_c), .sig(sig_c), .pass(pass_c));
    cut_bist_driver #(.N_PAT(16384)) u_d (
        .clk(clk), .rst(rst), .start(start_v[3]), .golden_sig(gold_d), .resp_in(resp_d),
        .pat_out(pat_d), .busy(busy_d), .done(done_d), .sig(sig_d), .pass(pass_d));

    int          sel = 0;
    logic        sel_busy, sel_done, sel_pass;
    logic [7:0]  sel_sig;
    logic [13:0] sel_pat;

    always_comb begin
        sel_busy = busy_a; sel_done = done_a; sel_pass = pass_a; sel_sig = sig_a; sel_pat = pat_a;
        case (sel)
            1: begin sel_busy = busy_b; sel_done = done_b; sel_pass = pass_b; sel_sig = sig_b; sel_pat = pat_b; end
            2: begin sel_busy = busy_c; sel_done = done_c; sel_pass = pass_c; sel_sig = sig_c; sel_pat = pat_c; end
            3: begin sel_busy = busy_d; sel_done = done_d; sel_pass = pass_d; sel_sig = sig_d; sel_pat = pat_d; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Optionally pulses start, then counts busy cycles until done (bounded).
    task automatic run_sel(input int s, input int npat, input bit do_start, input bit poke,
                           output int bc, output bit saw_zero,
                           output logic [13:0] p1, output logic [13:0] p2,
                           output logic [13:0] p3, output logic [13:0] plast);
        bit got_done;
        sel = s; bc = 0; saw_zero = 0; got_done = 0;
        p1 = '0; p2 = '0; p3 = '0; plast = '0;
        if (do_start) begin
            @(posedge clk); #1 start_v[s] = 1'b1;
            @(posedge clk); #1 start_v[s] = 1'b0;
        end
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (sel_done) begin
                got_done = 1;
                break;
            end
            if (sel_busy) begin
                bc++;
                if (sel_pat == 14'h0) saw_zero = 1;
                if (bc == 1) p1 = sel_pat;
                if (bc == 2) p2 = sel_pat;
                if (bc == 3) p3 = sel_pat;
                if (bc == npat) plast = sel_pat;
            end
            start_v[s] = poke && (bc == 3 || bc == 6);
        end
        start_v[s] = 1'b0;
        check("run_reaches_done", 32'(got_done), 32'd1);
    endtask

    typedef struct {
        int         s;
        logic [7:0] resp;
        logic [7:0] golden;
        logic [7:0] exp_sig;
        logic       exp_pass;
        int         exp_busy;
    } vec_t;

    vec_t        vecs[7];
    int          bc;
    bit          sz;
    logic [13:0] p1, p2, p3, pl;

    initial begin
        vecs[0] = '{0, 8'h01, 8'h03, 8'h03, 1'b1, 2 + PIPE};
        vecs[1] = '{0, 8'h01, 8'h02, 8'h03, 1'b0, 2 + PIPE};
        vecs[2] = '{1, 8'hA5, 8'hA5, 8'hA5, 1'b1, 1 + PIPE};
        vecs[3] = '{1, 8'hA5, 8'h00, 8'hA5, 1'b0, 1 + PIPE};
        vecs[4] = '{0, 8'h80, 8'h9D, 8'h9D, 1'b1, 2 + PIPE};
        vecs[5] = '{0, 8'h00, 8'h00, 8'h00, 1'b1, 2 + PIPE};
        vecs[6] = '{1, 8'h3C, 8'h3D, 8'h3C, 1'b0, 1 + PIPE};
        gold_c = model_sig(16);
        gold_d = model_sig(16384);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_pat", 32'(pat_c), 32'h0001);
        check("reset_sig", 32'(sig_c), 32'h00);
        check("reset_busy", 32'(busy_c), 32'd0);
        check("reset_done", 32'(done_c), 32'd0);
        check("reset_pass", 32'(pass_a), 32'd0);

        // Short runs from the vector table.
        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            if (vecs[v].s == 0) begin resp_a = vecs[v].resp; gold_a = vecs[v].golden; end
            else begin resp_b = vecs[v].resp; gold_b = vecs[v].golden; end
            run_sel(vecs[v].s, 1, 1'b1, 1'b0, bc, sz, p1, p2, p3, pl);
            check($sformatf("vec%0d_busy_cycles", v), 32'(bc), 32'(vecs[v].exp_busy));
            check($sformatf("vec%0d_sig", v), 32'(sel_sig), 32'(vecs[v].exp_sig));
            check($sformatf("vec%0d_pass", v), 32'(sel_pass), 32'(vecs[v].exp_pass));
            check($sformatf("vec%0d_done", v), 32'(sel_done), 32'd1);
        end

        // LFSR sequence and a clean 16-pattern reference run.
        run_sel(2, 16, 1'b1, 1'b0, bc, sz, p1, p2, p3, pl);
        check("lfsr_p1", 32'(p1), 32'h0001);
        check("lfsr_p2", 32'(p2), 32'h2015);
        check("lfsr_p3", 32'(p3), 32'h301F);
        check("c_busy_cycles", 32'(bc), 32'(16 + PIPE));
        check("c_sig", 32'(sig_c), 32'(model_sig(16)));
        check("c_pass", 32'(pass_c), 32'd1);

        // Reset in the fifth RUN cycle.
        sel = 2;
        @(posedge clk); #1 start_v[2] = 1'b1;
        @(posedge clk); #1 start_v[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_pat", 32'(pat_c), 32'h0001);
        check("midrst_sig", 32'(sig_c), 32'h00);
        check("midrst_busy", 32'(busy_c), 32'd0);
        check("midrst_done", 32'(done_c), 32'd0);
        run_sel(2, 16, 1'b1, 1'b0, bc, sz, p1, p2, p3, pl);
        check("after_rst_sig", 32'(sig_c), 32'(model_sig(16)));

        // start pulses during RUN are ignored.
        run_sel(2, 16, 1'b1, 1'b1, bc, sz, p1, p2, p3, pl);
        check("poke_busy_cycles", 32'(bc), 32'(16 + PIPE));
        check("poke_sig", 32'(sig_c), 32'(model_sig(16)));

        // start in DONE restarts immediately.
        @(posedge clk); #1 start_v[2] = 1'b1;
        @(posedge clk); #1 start_v[2] = 1'b0;
        @(negedge clk);
        check("restart_done_low", 32'(done_c), 32'd0);
        check("restart_busy", 32'(busy_c), 32'd1);
        run_sel(2, 16, 1'b0, 1'b0, bc, sz, p1, p2, p3, pl);
        check("restart_sig", 32'(sig_c), 32'(model_sig(16)));

        // Full LFSR period plus one wrap.
        run_sel(3, 16384, 1'b1, 1'b0, bc, sz, p1, p2, p3, pl);
        check("full_no_zero", 32'(sz), 32'd0);
        check("full_busy_cycles", 32'(bc), 32'(16384 + PIPE));
        check("full_pat16384", 32'(pl), 32'h0001);
        check("full_sig", 32'(sig_d), 32'(model_sig(16384)));
        check("full_pass", 32'(pass_d), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
